// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
//
// Frame-level sequencer for the mic -> Mel -> LED visualisation chain.
// A free-running frame timer produces one tick every CLK_HZ/FRAME_HZ cycles.
// Each accepted tick starts a frame:
//   capture a sample window -> wait for the last LED pixel -> hold the strip
//   latch time -> wait for the next tick.
// A watchdog covers CAPTURE+PROCESS. If it expires, the datapath is flushed
// and the frame is abandoned. A tick that arrives mid-frame is remembered
// once (pending). Any further mid-frame tick is counted as dropped.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous reset, active low
//   enable       in   run request (acted on in IDLE / WAIT_TICK)
//   clear_err    in   pulse: clears overrun and timeout_err
//   capture_done in   pulse: last sample of the frame emitted
//   pixel_fire   in   pulse: one pixel accepted by the RZ framer
//   led_idle     in   RZ bit sender idle / line low
//   capture_go   out  1-cycle pulse on CAPTURE entry
//   pipe_flush   out  1-cycle pulse on watchdog expiry
//   busy         out  high in CAPTURE, PROCESS, LATCH
//   state        out  FSM state (IDLE=0 .. LATCH=4)
//   frame_cnt    out  completed frames (wraps)
//   drop_cnt     out  dropped ticks (saturates)
//   overrun      out  sticky: a tick was dropped
//   timeout_err  out  sticky: watchdog fired
// -----------------------------------------------------------------------------
module frame_scheduler #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int FRAME_HZ      = 60,
  parameter int LED_NUM       = 60,
  parameter int RESET_TICKS   = 30_000,
  parameter int TIMEOUT_TICKS = 10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        clear_err,
  input  logic        capture_done,
  input  logic        pixel_fire,
  input  logic        led_idle,
  output logic        capture_go,
  output logic        pipe_flush,
  output logic        busy,
  output logic [2:0]  state,
  output logic [15:0] frame_cnt,
  output logic [7:0]  drop_cnt,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int FRAME_TICKS = CLK_HZ / FRAME_HZ;
  localparam int FT_W  = $clog2(FRAME_TICKS + 1);
  localparam int PIX_W = $clog2(LED_NUM + 1);
  localparam int LAT_W = $clog2(RESET_TICKS + 1);
  localparam int WD_W  = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [FT_W-1:0]  FT_LAST  = FT_W'(FRAME_TICKS - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(LED_NUM - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RESET_TICKS - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    CAPTURE   = 3'd2,
    PROCESS   = 3'd3,
    LATCH     = 3'd4
  } state_t;

  state_t           st;
  logic [FT_W-1:0]  frame_tmr;
  logic [PIX_W-1:0] pix_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic             pending;
  logic             tick;
  logic             in_frame;
  logic             wd_expired;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign state      = st;
  assign tick       = enable && (frame_tmr == FT_LAST);
  assign in_frame   = (st == CAPTURE) || (st == PROCESS) || (st == LATCH);
  assign wd_expired = (wd_cnt == WD_LAST);

  // Frame timer runs only while enabled so the first tick always lands
  // exactly one frame period after enable rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_tmr <= '0;
    end else if (!enable || (frame_tmr == FT_LAST)) begin
      frame_tmr <= '0;
    end else begin
      frame_tmr <= frame_tmr + FT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= IDLE;
      capture_go  <= 1'b0;
      pipe_flush  <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= '0;
      drop_cnt    <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      pending     <= 1'b0;
      pix_cnt     <= '0;
      lat_cnt     <= '0;
      wd_cnt      <= '0;
    end else begin
      capture_go <= 1'b0;
      pipe_flush <= 1'b0;

      // Clear first so a coincident set later in this block takes priority.
      if (clear_err) begin
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end

      // One mid-frame tick is remembered; any further one is a drop.
      if (tick && in_frame) begin
        if (!pending) begin
          pending <= 1'b1;
        end else begin
          overrun  <= 1'b1;
          drop_cnt <= sat_inc8(drop_cnt);
        end
      end

      case (st)
        IDLE: begin
          busy <= 1'b0;
          if (enable) st <= WAIT_TICK;
        end

        WAIT_TICK: begin
          if (!enable) begin
            st      <= IDLE;
            pending <= 1'b0;
          end else if (tick || pending) begin
            st         <= CAPTURE;
            pending    <= 1'b0;
            capture_go <= 1'b1;
            busy       <= 1'b1;
            wd_cnt     <= '0;
          end
        end

        // Watchdog check precedes the normal exit so a coincident
        // capture_done / final pixel still ends in a flush.
        CAPTURE: begin
          if (wd_expired) begin
            st          <= WAIT_TICK;
            busy        <= 1'b0;
            pipe_flush  <= 1'b1;
            timeout_err <= 1'b1;
            pix_cnt     <= '0;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
            if (capture_done) st <= PROCESS;
          end
        end

        PROCESS: begin
          if (wd_expired) begin
            st          <= WAIT_TICK;
            busy        <= 1'b0;
            pipe_flush  <= 1'b1;
            timeout_err <= 1'b1;
            pix_cnt     <= '0;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
            if (pixel_fire) begin
              if (pix_cnt == PIX_LAST) begin
                st      <= LATCH;
                pix_cnt <= '0;
                lat_cnt <= '0;
              end else begin
                pix_cnt <= pix_cnt + PIX_W'(1);
              end
            end
          end
        end

        // The strip latches only after an unbroken run of idle cycles.
        LATCH: begin
          if (!led_idle) begin
            lat_cnt <= '0;
          end else if (lat_cnt == LAT_LAST) begin
            st        <= WAIT_TICK;
            busy      <= 1'b0;
            lat_cnt   <= '0;
            frame_cnt <= frame_cnt + 16'd1;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end

        default: begin
          st   <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_scheduler
//
// Directed bench for frame_scheduler with a 100-cycle frame, 4 pixels per
// frame, an 8-cycle latch and a 50-cycle watchdog. The expected cycle
// positions are hand-derived from the tick grid and the stimulus offsets.
// -----------------------------------------------------------------------------
module tb_frame_scheduler;

  logic        clk          = 1'b0;
  logic        rst_n        = 1'b0;
  logic        enable       = 1'b0;
  logic        clear_err    = 1'b0;
  logic        capture_done = 1'b0;
  logic        pixel_fire   = 1'b0;
  logic        led_idle     = 1'b1;
  logic        capture_go;
  logic        pipe_flush;
  logic        busy;
  logic [2:0]  state;
  logic [15:0] frame_cnt;
  logic [7:0]  drop_cnt;
  logic        overrun;
  logic        timeout_err;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;
  int t_go, t_lat, t_high, c0, t1, t2, gos;

  frame_scheduler #(
    .CLK_HZ       (1000),
    .FRAME_HZ     (10),
    .LED_NUM      (4),
    .RESET_TICKS  (8),
    .TIMEOUT_TICKS(50)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .clear_err   (clear_err),
    .capture_done(capture_done),
    .pixel_fire  (pixel_fire),
    .led_idle    (led_idle),
    .capture_go  (capture_go),
    .pipe_flush  (pipe_flush),
    .busy        (busy),
    .state       (state),
    .frame_cnt   (frame_cnt),
    .drop_cnt    (drop_cnt),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {29'd0, state}, {29'd0, s});
  endtask

  task automatic wait_go(input int budget, input string tag);
    int n = 0;
    while (capture_go !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, capture_go}, 32'd1);
    t_go = cyc;
  endtask

  // Capture phase: a stray pixel in CAPTURE, capture_done 10 cycles after go.
  task automatic do_capture();
    chk("busy_capture", {31'd0, busy}, 32'd1);
    chk("state_capture", {29'd0, state}, 32'd2);
    step_to(t_go + 5);
    pixel_fire = 1'b1;
    @(negedge clk);
    pixel_fire = 1'b0;
    step_to(t_go + 10);
    capture_done = 1'b1;
    @(negedge clk);
    capture_done = 1'b0;
    chk("enter_process", {29'd0, state}, 32'd3);
  endtask

  // Four pixels, one every other cycle; LATCH is entered at t_go+18.
  task automatic do_pixels();
    for (int i = 0; i < 4; i++) begin
      pixel_fire = 1'b1;
      @(negedge clk);
      pixel_fire = 1'b0;
      if (i == 2) chk("pix3_still_process", {29'd0, state}, 32'd3);
      if (i < 3) @(negedge clk);
    end
    chk("enter_latch", {29'd0, state}, 32'd4);
    t_lat = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_go", {31'd0, capture_go}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_enable", {29'd0, state}, 32'd0);

    // 1: nominal frame, first tick one period after enable
    enable = 1'b1;
    c0 = cyc;
    wait_go(150, "first_go");
    chk("first_go_latency", 32'(t_go - c0), 32'd100);
    do_capture();
    do_pixels();
    wait_state(3'd1, 20, "latch_exit");
    chk("latch_len", 32'(cyc - t_lat), 32'd8);
    chk("frame_cnt_1", {16'd0, frame_cnt}, 32'd1);
    chk("busy_wait", {31'd0, busy}, 32'd0);

    // 2: led_idle glitch restarts the latch count
    c0 = t_go;
    wait_go(150, "go_2");
    chk("go_period", 32'(t_go - c0), 32'd100);
    do_capture();
    do_pixels();
    step_to(t_lat + 5);
    led_idle = 1'b0;
    step_to(t_lat + 8);
    chk("latch_held", {29'd0, state}, 32'd4);
    led_idle = 1'b1;
    t_high = cyc;
    wait_state(3'd1, 30, "glitch_exit");
    chk("glitch_latch_len", 32'(cyc - t_high), 32'd8);
    chk("frame_cnt_2", {16'd0, frame_cnt}, 32'd2);

    // 3: strip held busy across two ticks -> pending, then overrun
    c0 = t_go;
    wait_go(150, "go_3");
    chk("go_period_3", 32'(t_go - c0), 32'd100);
    c0 = t_go;
    do_capture();
    do_pixels();
    led_idle = 1'b0;
    step_to(c0 + 150);
    chk("pending_no_overrun", {31'd0, overrun}, 32'd0);
    chk("pending_no_drop", {24'd0, drop_cnt}, 32'd0);
    step_to(c0 + 201);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    chk("drop_1", {24'd0, drop_cnt}, 32'd1);
    step_to(c0 + 250);
    led_idle = 1'b1;
    wait_state(3'd1, 20, "overrun_latch_exit");
    chk("overrun_exit_cycle", 32'(cyc - c0), 32'd258);
    @(negedge clk);
    chk("pending_immediate_go", {31'd0, capture_go}, 32'd1);
    chk("frame_cnt_3", {16'd0, frame_cnt}, 32'd3);
    t1 = cyc;

    // 4: no capture_done -> watchdog flush 50 cycles after entry
    step_to(t1 + 49);
    chk("no_flush_early", {31'd0, pipe_flush}, 32'd0);
    chk("still_capture", {29'd0, state}, 32'd2);
    step_to(t1 + 50);
    chk("flush_pulse", {31'd0, pipe_flush}, 32'd1);
    chk("timeout_wait", {29'd0, state}, 32'd1);
    chk("timeout_err_set", {31'd0, timeout_err}, 32'd1);
    chk("timeout_frame_cnt", {16'd0, frame_cnt}, 32'd3);
    @(negedge clk);
    chk("flush_one_cycle", {31'd0, pipe_flush}, 32'd0);
    chk("go_from_pending", {31'd0, capture_go}, 32'd1);
    chk("drop_still_1", {24'd0, drop_cnt}, 32'd1);
    t2 = cyc;

    // timeout coincident with capture_done and clear_err
    step_to(t2 + 49);
    capture_done = 1'b1;
    clear_err    = 1'b1;
    @(negedge clk);
    capture_done = 1'b0;
    clear_err    = 1'b0;
    chk("timeout_beats_done", {29'd0, state}, 32'd1);
    chk("flush_pulse_2", {31'd0, pipe_flush}, 32'd1);
    chk("set_beats_clear", {31'd0, timeout_err}, 32'd1);
    chk("overrun_cleared", {31'd0, overrun}, 32'd0);
    chk("drop_kept_1", {24'd0, drop_cnt}, 32'd1);
    chk("frame_cnt_kept", {16'd0, frame_cnt}, 32'd3);

    // 5: clear_err, then enable dropped mid-PROCESS
    step_to(t2 + 55);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("clear_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("clear_overrun", {31'd0, overrun}, 32'd0);
    chk("clear_keeps_drop", {24'd0, drop_cnt}, 32'd1);
    wait_go(100, "go_after_clear");
    chk("go_after_clear_cycle", 32'(t_go - t2), 32'd90);
    do_capture();
    enable = 1'b0;
    do_pixels();
    wait_state(3'd1, 20, "disabled_latch_exit");
    chk("frame_cnt_4", {16'd0, frame_cnt}, 32'd4);
    @(negedge clk);
    chk("back_to_idle", {29'd0, state}, 32'd0);
    gos = 0;
    repeat (150) begin
      @(negedge clk);
      if (capture_go) gos++;
    end
    chk("no_go_disabled", 32'(gos), 32'd0);

    // 6: async reset mid-PROCESS, then a clean restart
    enable = 1'b1;
    c0 = cyc;
    wait_go(150, "go_reenable");
    chk("reenable_latency", 32'(t_go - c0), 32'd100);
    do_capture();
    pixel_fire = 1'b1;
    @(negedge clk);
    pixel_fire = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", {29'd0, state}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("arst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    chk("arst_flush", {31'd0, pipe_flush}, 32'd0);
    repeat (3) @(negedge clk);
    chk("arst_held_flush", {31'd0, pipe_flush}, 32'd0);
    rst_n = 1'b1;
    c0 = cyc;
    wait_go(150, "go_after_reset");
    chk("reset_restart_latency", 32'(t_go - c0), 32'd100);
    do_capture();
    do_pixels();
    wait_state(3'd1, 20, "restart_latch_exit");
    chk("restart_latch_len", 32'(cyc - t_lat), 32'd8);
    chk("restart_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
